// File: rtl/mem_fetch_unpack.sv
// -----------------------------------------------------------------------------
// mem_fetch_unpack
//
// Upstream feeder for the Minilab1 matrix-vector datapath. After a start pulse
// it reads NUM_ROWS+1 words from memory over an Avalon-MM read master. Word 0
// at BASE_ADDR is the B vector and word k (1..NUM_ROWS) is row k-1 of A. Each
// MEM_W-bit word is split into ROW_LEN bytes, most significant byte first.
// The bytes go to the B FIFO (word 0) or to A FIFO k-1 (word k).
//
// Ports
//   clk            system clock (CLOCK_50 at the top level)
//   rst            synchronous active-high reset
//   start          1-cycle start pulse, honoured only while idle
//   busy           high in every state except IDLE
//   done           1-cycle pulse after the last byte has been written
//   address        Avalon read word address
//   read           Avalon read request
//   waitrequest    Avalon stall; a request is accepted when read=1, waitrequest=0
//   readdata       Avalon read data (MEM_W bits)
//   readdatavalid  readdata qualifier
//   a_wr_en        one-hot write enables of the A row FIFOs
//   b_wr_en        write enable of the B FIFO
//   wr_data        byte shared by all FIFO write ports
//   a_full         A FIFO full flags
//   b_full         B FIFO full flag
//
// Build option
//   FETCH_PREFETCH_EN  When defined, a spare word buffer is added. The read for
//                      word k+1 is issued while word k is being unpacked, so
//                      the memory latency is hidden behind the unpack phase.
//                      At most one read is outstanding at any time. When not
//                      defined, only one word is in flight.
// -----------------------------------------------------------------------------
module mem_fetch_unpack #(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ROW_LEN   = 8,
    parameter int unsigned       NUM_ROWS  = 8,
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [ADDR_W-1:0]         address,
    output logic                      read,
    input  logic                      waitrequest,
    input  logic [DATA_W*ROW_LEN-1:0] readdata,
    input  logic                      readdatavalid,
    output logic [NUM_ROWS-1:0]       a_wr_en,
    output logic                      b_wr_en,
    output logic [DATA_W-1:0]         wr_data,
    input  logic [NUM_ROWS-1:0]       a_full,
    input  logic                      b_full
);

    localparam int unsigned MEM_W  = DATA_W * ROW_LEN;
    localparam int unsigned WIDX_W = $clog2(NUM_ROWS + 1);
    localparam int unsigned BIDX_W = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;

    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(NUM_ROWS);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(ROW_LEN - 1);
    localparam logic [WIDX_W-1:0] WIDX_ONE  = WIDX_W'(1);
    localparam logic [BIDX_W-1:0] BIDX_ONE  = BIDX_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_UNPACK,
        S_DONE
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t            state_reg;
    logic [WIDX_W-1:0] word_idx_reg;
    logic [BIDX_W-1:0] byte_idx_reg;
    logic [MEM_W-1:0]  word_buf_reg;
    logic [ADDR_W-1:0] address_reg;

`ifdef FETCH_PREFETCH_EN
    // Prefetch tracking. pf_req_reg means a read for the next word is being
    // presented but has not been accepted yet. pf_out_reg means that read was
    // accepted and its data is still pending. spare_valid_reg means the data
    // has arrived in spare_buf_reg.
    logic [MEM_W-1:0]  spare_buf_reg;
    logic              spare_valid_reg;
    logic              pf_req_reg;
    logic              pf_out_reg;
    logic [ADDR_W-1:0] pf_after_next_addr;
    logic              pf_accept;
    logic              pf_data;
`endif

    // -------------------------------------------------------------------------
    // Decode of the current word and byte
    // -------------------------------------------------------------------------
    logic [NUM_ROWS-1:0] row_sel;
    logic [DATA_W-1:0]   lane [ROW_LEN];
    logic                tgt_is_b;
    logic                tgt_full;
    logic                write_fire;
    logic                last_byte;
    logic                last_word;
    logic [WIDX_W-1:0]   next_word;
    logic [ADDR_W-1:0]   next_word_addr;

    genvar gi;
    generate
        // row_sel[r] is high while word r+1 (row r of A) is the current word.
        for (gi = 0; gi < NUM_ROWS; gi++) begin : g_row_sel
            assign row_sel[gi] = (word_idx_reg == WIDX_W'(gi + 1));
        end
        // Lane 0 is the most significant byte of the word, so that bytes are
        // sent MSB first.
        for (gi = 0; gi < ROW_LEN; gi++) begin : g_lane
            assign lane[gi] = word_buf_reg[MEM_W-1-DATA_W*gi -: DATA_W];
        end
    endgenerate

    assign tgt_is_b       = (word_idx_reg == '0);
    assign tgt_full       = tgt_is_b ? b_full : |(row_sel & a_full);
    assign write_fire     = (state_reg == S_UNPACK) && !tgt_full;
    assign last_byte      = (byte_idx_reg == LAST_BYTE);
    assign last_word      = (word_idx_reg == LAST_WORD);
    assign next_word      = word_idx_reg + WIDX_ONE;
    assign next_word_addr = BASE_ADDR + ADDR_W'(next_word);

    // The write strobes depend on the full flag in the same cycle. A stalled
    // byte is never dropped because byte_idx only advances on write_fire.
    assign a_wr_en = write_fire ? row_sel : '0;
    assign b_wr_en = write_fire && tgt_is_b;
    assign wr_data = (state_reg == S_UNPACK) ? lane[byte_idx_reg] : '0;

    // Status outputs are straight decodes of the state register.
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);
    assign address = address_reg;

`ifdef FETCH_PREFETCH_EN
    assign read               = (state_reg == S_REQ) || pf_req_reg;
    assign pf_accept          = pf_req_reg && !waitrequest;
    assign pf_data            = pf_out_reg && readdatavalid;
    assign pf_after_next_addr = next_word_addr + ADDR_W'(1);
`else
    assign read = (state_reg == S_REQ);
`endif

    // -------------------------------------------------------------------------
    // Control FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            word_idx_reg <= '0;
            byte_idx_reg <= '0;
            word_buf_reg <= '0;
            address_reg  <= BASE_ADDR;
`ifdef FETCH_PREFETCH_EN
            spare_buf_reg   <= '0;
            spare_valid_reg <= 1'b0;
            pf_req_reg      <= 1'b0;
            pf_out_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_REQ;
                        word_idx_reg <= '0;
                        byte_idx_reg <= '0;
                        address_reg  <= BASE_ADDR;
                    end
                end

                // read and address come from registers, so they stay stable
                // for as long as waitrequest holds the request off.
                S_REQ: begin
                    if (!waitrequest) begin
                        state_reg <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (readdatavalid) begin
                        word_buf_reg <= readdata;
                        byte_idx_reg <= '0;
                        state_reg    <= S_UNPACK;
`ifdef FETCH_PREFETCH_EN
                        if (!last_word) begin
                            pf_req_reg  <= 1'b1;
                            address_reg <= next_word_addr;
                        end
`endif
                    end
                end

                S_UNPACK: begin
`ifdef FETCH_PREFETCH_EN
                    // Background prefetch progress. The end-of-word handling
                    // below can override these updates.
                    if (pf_accept) begin
                        pf_req_reg <= 1'b0;
                        pf_out_reg <= 1'b1;
                    end
                    if (pf_data) begin
                        spare_buf_reg   <= readdata;
                        spare_valid_reg <= 1'b1;
                        pf_out_reg      <= 1'b0;
                    end
`endif
                    if (write_fire) begin
                        if (!last_byte) begin
                            byte_idx_reg <= byte_idx_reg + BIDX_ONE;
                        end else begin
                            byte_idx_reg <= '0;
                            if (last_word) begin
                                state_reg <= S_DONE;
                            end else begin
                                word_idx_reg <= next_word;
`ifdef FETCH_PREFETCH_EN
                                if (spare_valid_reg || pf_data) begin
                                    // Next word is already here. Data that
                                    // arrives on this last cycle bypasses the
                                    // spare buffer.
                                    word_buf_reg    <= spare_valid_reg ? spare_buf_reg : readdata;
                                    spare_valid_reg <= 1'b0;
                                    pf_out_reg      <= 1'b0;
                                    state_reg       <= S_UNPACK;
                                    if (next_word != LAST_WORD) begin
                                        pf_req_reg  <= 1'b1;
                                        address_reg <= pf_after_next_addr;
                                    end
                                end else if (pf_out_reg || pf_accept) begin
                                    // Read accepted but data pending: WAIT
                                    // now owns the outstanding read.
                                    pf_out_reg <= 1'b0;
                                    pf_req_reg <= 1'b0;
                                    state_reg  <= S_WAIT;
                                end else begin
                                    // Read still stalled. REQ keeps driving
                                    // the same address without a gap.
                                    pf_req_reg  <= 1'b0;
                                    address_reg <= next_word_addr;
                                    state_reg   <= S_REQ;
                                end
`else
                                address_reg <= next_word_addr;
                                state_reg   <= S_REQ;
`endif
                            end
                        end
                    end
                end

                S_DONE: begin
                    state_reg <= S_IDLE;
                end

                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_fetch_unpack.sv
// -----------------------------------------------------------------------------
// tb_mem_fetch_unpack
//
// Scoreboard bench for mem_fetch_unpack. For each run, the expected FIFO
// writes are computed from the memory image and queued in order. These are the
// B bytes first, then rows 0..7 of A, each word sent MSB byte first. A monitor
// pops the queue on every write strobe and compares the entry with the write.
// A behavioural memory model serves the Avalon reads. It also checks that the
// request addresses come in order, that stalled requests are held stable, and
// that each run issues exactly NUM_ROWS+1 accepted requests.
// -----------------------------------------------------------------------------
module tb_mem_fetch_unpack;

    localparam int NUM_ROWS = 8;
    localparam int NWORDS   = NUM_ROWS + 1;
`ifdef FETCH_PREFETCH_EN
    localparam int IDEAL_DONE = 75;
`else
    localparam int IDEAL_DONE = 91;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] address;
    logic        read;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [7:0]  a_wr_en;
    logic        b_wr_en;
    logic [7:0]  wr_data;
    logic [7:0]  a_full;
    logic        b_full;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    int          c0    = 0;
    int          exp_q[$];
    logic [63:0] mem [0:NWORDS-1];
    int          stray_req = 0;
    int          stall_req = 0;

    mem_fetch_unpack dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .address       (address),
        .read          (read),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .a_wr_en       (a_wr_en),
        .b_wr_en       (b_wr_en),
        .wr_data       (wr_data),
        .a_full        (a_full),
        .b_full        (b_full)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference: target k receives word k one byte at a time, MSB byte first.
    // Each entry is encoded as (target << 8) | byte, with target 0 = B FIFO.
    task automatic push_expected();
        for (int k = 0; k < NWORDS; k++) begin
            for (int j = 0; j < 8; j++) begin
                logic [63:0] w;
                w = mem[k] >> (56 - 8 * j);
                exp_q.push_back((k << 8) | int'(w[7:0]));
            end
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < NWORDS; k++) mem[k] = {$urandom, $urandom};
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 start = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc - c0;
                break;
            end
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic wait_write(input int row, input int nth);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 1000 && cnt < nth; i++) begin
            @(negedge clk);
            if (!rst && a_wr_en[row]) cnt++;
        end
        chk("write_seen", cnt, nth);
    endtask

    // Monitor: every FIFO write is checked against the scoreboard.
    initial begin : monitor
        int tgt;
        int e;
        forever begin
            @(negedge clk);
            if (!rst && (b_wr_en || a_wr_en != 8'd0)) begin
                tgt = 0;
                for (int r = 0; r < NUM_ROWS; r++) if (a_wr_en[r]) tgt = r + 1;
                chk("wr_onehot", $countones({a_wr_en, b_wr_en}), 1);
                chk("wr_into_full", {63'd0, (b_wr_en && b_full) || ((a_wr_en & a_full) != 8'd0)}, 64'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL wr_unexpected: got target %0d byte 0x%0h, expected no write", tgt, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_byte", (tgt << 8) | int'(wr_data), e);
                end
            end
        end
    end

    // Avalon memory model: accepts a request when read=1 and waitrequest=0,
    // and returns the data on the following cycle.
    initial begin : memory
        bit          pend;
        int          pend_addr;
        int          acc_idx;
        int          stray_done;
        int          stall_left;
        bit          prev_stall;
        logic [31:0] prev_addr;
        pend = 0; pend_addr = 0; acc_idx = 0; stray_done = 0;
        stall_left = 5; prev_stall = 0; prev_addr = '0;
        waitrequest = 1'b0; readdatavalid = 1'b0; readdata = '0;
        forever begin
            @(negedge clk);
            readdatavalid = pend;
            readdata      = pend ? mem[pend_addr] : 64'd0;
            pend          = 0;
            if (stray_req != stray_done) begin
                stray_done    = stray_req;
                readdatavalid = 1'b1;
                readdata      = {$urandom, $urandom};
            end
            if (prev_stall) begin
                chk("hold_read", {63'd0, read}, 64'd1);
                chk("hold_addr", address, prev_addr);
            end
            waitrequest = (stall_req != 0) && read && (address == 32'd3) && (stall_left > 0);
            if (waitrequest) stall_left--;
            prev_stall = waitrequest;
            prev_addr  = address;
            if (rst) begin
                acc_idx = 0;
            end else if (read && !waitrequest) begin
                chk("req_addr", address, acc_idx);
                acc_idx++;
                pend      = 1;
                pend_addr = (address < NWORDS) ? int'(address) : 0;
            end
            if (done && !rst) begin
                chk("accept_count", acc_idx, NWORDS);
                acc_idx = 0;
            end
        end
    end

    initial begin : stimulus
        int dc;
        int seen;
        logic [7:0] kb;
        rst = 1'b1; start = 1'b0; a_full = '0; b_full = 1'b0;
        for (int k = 0; k < NWORDS; k++) mem[k] = '0;

        // Reset state and idle behaviour
        repeat (2) @(posedge clk);
        #1;
        chk("rst_read",    {63'd0, read},    64'd0);
        chk("rst_a_wr_en", {56'd0, a_wr_en}, 64'd0);
        chk("rst_b_wr_en", {63'd0, b_wr_en}, 64'd0);
        chk("rst_done",    {63'd0, done},    64'd0);
        chk("rst_busy",    {63'd0, busy},    64'd0);
        chk("rst_address", {32'd0, address}, 64'd0);
        chk("rst_wr_data", {56'd0, wr_data}, 64'd0);
        rst = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (read || busy) seen++;
        end
        chk("idle_quiet", seen, 0);

        // Run A: ideal memory, word k = {8{k}}
        for (int k = 0; k < NWORDS; k++) begin
            kb = 8'(k);
            mem[k] = {8{kb}};
        end
        push_expected();
        do_start();
        wait_done(dc);
        chk("done_cycle_ideal", dc, IDEAL_DONE);
        chk("queue_empty_a", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        // Run B: waitrequest stall on word 3, start while busy, stray readdatavalid
        fill_random();
        push_expected();
        stall_req = 1;
        do_start();
        repeat (15) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_write(7, 1);
        stray_req++;
        wait_done(dc);
        chk("queue_empty_b", exp_q.size(), 0);
        stall_req = 0;
        repeat (3) @(posedge clk);

        // Run C: a_full[2] high for 4 cycles in the middle of row 2
        fill_random();
        push_expected();
        do_start();
        wait_write(2, 3);
        @(posedge clk);
        #1 a_full[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1 a_full[2] = 1'b0;
        wait_done(dc);
        chk("done_cycle_full_stall", dc, IDEAL_DONE + 4);
        chk("queue_empty_c", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        // Run D: reset while unpacking word 5, late readdatavalid, restart
        fill_random();
        push_expected();
        do_start();
        wait_write(4, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_read", {63'd0, read}, 64'd0);
        stray_req++;
        repeat (4) @(negedge clk);
        chk("late_rdv_busy", {63'd0, busy}, 64'd0);
        fill_random();
        push_expected();
        do_start();
        wait_done(dc);
        chk("done_cycle_restart", dc, IDEAL_DONE);
        chk("queue_empty_d", exp_q.size(), 0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
